uart_tx_arbiter: RTL and testbench

Shares one `uart_tx_8n1` transmitter between `NREQ` byte producers, such as the rx echo path, a status reporter and a keypad scanner, using round-robin grant. Each producer uses a valid/ready handshake. The arbiter holds `tx_send`/`tx_byte` to the transmitter until `tx_done`, then enforces an optional inter-byte gap. A watchdog recovers if the transmitter never reports done. The block sits between the producers and the transmitter in `top`, all on `hwclk`.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_rr_pick.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART-side types and the rotating-priority pick used by the byte arbiters.
package uart_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int RR_MAX_N    = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        GAP
    } arb_state_t;

    typedef struct packed {
        logic [2:0] idx;
        logic       found;
    } rr_pick_t;

    // First set bit of valid at or above ptr, wrapping at n; lower offsets win.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] valid,
                                         input logic [2:0]          ptr,
                                         input int                  n = RR_MAX_N);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = RR_MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (valid[j[2:0]]) begin
                    r.idx   = j[2:0];
                    r.found = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority encoder over N request bits.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    rr_pick_t res;

    always_comb begin
        res = rr_pick(RR_MAX_N'(valid), 3'(ptr), N);
    end

    assign idx   = W'(res.idx);
    assign found = res.found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one byte transmitter among NREQ producers, with
// optional post-byte gap and a done-watchdog that drops the stuck byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NREQ           = 4,
    parameter  int GAP_CYCLES     = 0,
    parameter  int TIMEOUT_CYCLES = 0,
    localparam int GID_W          = $clog2(NREQ)
) (
    input  logic                         hwclk,
    input  logic                         reset_n,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*UART_BYTE_W-1:0]  req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         tx_send,
    output logic [UART_BYTE_W-1:0]       tx_byte,
    input  logic                         tx_done,
    output logic                         busy,
    output logic [GID_W-1:0]             grant_id,
    output logic                         err_timeout,
    input  logic                         err_clear
);

    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam bit HAS_GAP = GAP_CYCLES > 0;
    localparam bit HAS_WD  = TIMEOUT_CYCLES > 0;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(HAS_WD ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GID_W-1:0]       ptr_q, ptr_d;
    logic [NREQ-1:0]        ready_d;
    logic                   send_d, busy_d, err_d;
    logic [UART_BYTE_W-1:0] byte_d;
    logic [GID_W-1:0]       gid_d;
    logic [GID_W-1:0]       pick_idx;
    logic                   pick_found;

    uart_rr_pick #(.N(NREQ)) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ready_d = '0;
        send_d  = tx_send;
        byte_d  = tx_byte;
        gid_d   = grant_id;
        err_d   = err_timeout;
        if (err_clear) err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d           = WAIT_DONE;
                    cnt_d             = '0;
                    ready_d[pick_idx] = 1'b1;
                    send_d            = 1'b1;
                    byte_d            = req_data[pick_idx*UART_BYTE_W +: UART_BYTE_W];
                    gid_d             = pick_idx;
                    ptr_d             = (pick_idx == GID_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                // A real done in the expiry cycle wins over the watchdog.
                if (tx_done || (HAS_WD && cnt_q == TO_LAST)) begin
                    if (!tx_done) err_d = 1'b1;
                    send_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = HAS_GAP ? GAP : IDLE;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            req_ready   <= '0;
            tx_send     <= 1'b0;
            tx_byte     <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            req_ready   <= ready_d;
            tx_send     <= send_d;
            tx_byte     <= byte_d;
            busy        <= busy_d;
            grant_id    <= gid_d;
            err_timeout <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance without gap, one with a 3-cycle gap.
module tb_uart_tx_arbiter;

    logic        hwclk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_send;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        err_timeout;
    logic        err_clear;

    logic [3:0]  b_valid;
    logic [31:0] b_data;
    logic [3:0]  b_ready;
    logic        b_send;
    logic [7:0]  b_byte;
    logic        b_done;
    logic        b_busy;
    logic [1:0]  b_gid;
    logic        b_err;
    logic        b_clear;

    int n_checks = 0;
    int n_errors = 0;

    always #5 hwclk = ~hwclk;

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(20)) dut (
        .hwclk(hwclk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_send(tx_send), .tx_byte(tx_byte), .tx_done(tx_done),
        .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout), .err_clear(err_clear)
    );

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(3), .TIMEOUT_CYCLES(20)) dut_gap (
        .hwclk(hwclk), .reset_n(reset_n), .req_valid(b_valid), .req_data(b_data),
        .req_ready(b_ready), .tx_send(b_send), .tx_byte(b_byte), .tx_done(b_done),
        .busy(b_busy), .grant_id(b_gid), .err_timeout(b_err), .err_clear(b_clear)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"}, 32'(req_ready), 32'h0);
        check({tag, " send"},  32'(tx_send),   32'h0);
        check({tag, " byte"},  32'(tx_byte),   32'h0);
        check({tag, " busy"},  32'(busy),      32'h0);
        check({tag, " gid"},   32'(grant_id),  32'h0);
        check({tag, " err"},   32'(err_timeout), 32'h0);
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        reset_n = 1'b0;
        req_valid = '0; req_data = '0; tx_done = 1'b0; err_clear = 1'b0;
        b_valid = '0; b_data = '0; b_done = 1'b0; b_clear = 1'b0;
        #12;
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // single request
        req_valid = 4'b0001; req_data[7:0] = 8'h46;
        tick();
        check("single ready", 32'(req_ready), 32'h1);
        check("single send",  32'(tx_send),   32'h1);
        check("single byte",  32'(tx_byte),   32'h46);
        check("single busy",  32'(busy),      32'h1);
        req_valid = '0;
        tick();
        check("single ready low", 32'(req_ready), 32'h0);
        check("single send held", 32'(tx_send),   32'h1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("single send drop", 32'(tx_send), 32'h0);
        check("single idle",      32'(busy),    32'h0);

        // round robin from a fresh pointer
        reset_n = 1'b0; #2; reset_n = 1'b1;
        req_data = 32'hA3A2A1A0; req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr send",  32'(tx_send),   32'h1);
            check("rr gid",   32'(grant_id),  32'(order[i]));
            check("rr byte",  32'(tx_byte),   32'hA0 + 32'(order[i]));
            check("rr ready", 32'(req_ready), 32'h1 << order[i]);
            if (i == 4) req_valid = '0;
            repeat (4) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            check("rr drop", 32'(tx_send), 32'h0);
        end

        // stray done in idle
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("stray busy", 32'(busy),        32'h0);
        check("stray send", 32'(tx_send),     32'h0);
        check("stray err",  32'(err_timeout), 32'h0);

        // watchdog expiry (ptr is 1 here)
        req_valid = 4'b0010; req_data[15:8] = 8'h55;
        tick();
        req_valid = '0;
        check("to gid", 32'(grant_id), 32'h1);
        repeat (19) tick();
        check("to send before", 32'(tx_send),     32'h1);
        check("to err before",  32'(err_timeout), 32'h0);
        tick();
        check("to err",  32'(err_timeout), 32'h1);
        check("to send", 32'(tx_send),     32'h0);
        check("to busy", 32'(busy),        32'h0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clear", 32'(err_timeout), 32'h0);

        // clear in the expiry cycle: set wins
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        check("to2 gid", 32'(grant_id), 32'h2);
        repeat (19) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("set wins", 32'(err_timeout), 32'h1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clear2", 32'(err_timeout), 32'h0);

        // done in the expiry cycle: no error
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        check("to3 gid", 32'(grant_id), 32'h3);
        repeat (19) tick();
        check("to3 send before", 32'(tx_send), 32'h1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("done wins err",  32'(err_timeout), 32'h0);
        check("done wins send", 32'(tx_send),     32'h0);

        // reset while waiting for done (ptr 0 -> grants 1 -> ptr 2)
        req_valid = 4'b0010; req_data[15:8] = 8'h77;
        tick();
        check("mid gid",  32'(grant_id), 32'h1);
        check("mid send", 32'(tx_send),  32'h1);
        req_valid = '0;
        #2; reset_n = 1'b0; #1;
        check_all_zero("async reset");
        req_valid = 4'b0011; req_data[7:0] = 8'h11;
        #2; reset_n = 1'b1;
        tick();
        check("post reset gid",  32'(grant_id), 32'h0);
        check("post reset byte", 32'(tx_byte),  32'h11);
        req_valid = '0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;

        // gap instance: done at M, next send rises at M+5
        b_valid = 4'b0011; b_data[15:0] = 16'h2211;
        tick();
        check("gap first gid", 32'(b_gid), 32'h0);
        b_valid = 4'b0010;
        tick();
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        check("gap drop", 32'(b_send), 32'h0);
        check("gap busy", 32'(b_busy), 32'h1);
        repeat (3) tick();
        check("gap M+4 send", 32'(b_send), 32'h0);
        check("gap M+4 busy", 32'(b_busy), 32'h0);
        tick();
        check("gap M+5 send", 32'(b_send), 32'h1);
        check("gap M+5 gid",  32'(b_gid),  32'h1);
        check("gap M+5 byte", 32'(b_byte), 32'h22);
        b_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
